// File: rtl/ritc_delay_trainer_pkg.sv
// Shared types and IDELAY word layout for the RITC delay trainer.
package ritc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_RECORD,
      ST_CENTER,
      ST_FINAL_WRITE,
      ST_DONE
   } state_t;

   localparam int TAP_W    = 5;
   localparam int TAP_LSB  = 0;
   localparam int BIT_LSB  = 6;
   localparam int CH_LSB   = 10;
   localparam int LOAD_BIT = 12;
   localparam int RITC_BIT = 13;

   localparam logic [3:0] BIT_SEL_CLK = 4'hF;

   // Data bits 0..11 and the clock lane are scannable; channel 3 does not exist.
   function automatic logic sel_legal(input logic [1:0] ch, input logic [3:0] bsel);
      return (ch != 2'd3) && ((bsel <= 4'd11) || (bsel == BIT_SEL_CLK));
   endfunction

   function automatic logic [31:0] dly_word(input logic [TAP_W-1:0] tap,
                                            input logic             rsel,
                                            input logic [1:0]       ch,
                                            input logic [3:0]       bsel);
      logic [31:0] w;
      w                    = '0;
      w[TAP_LSB +: TAP_W]  = tap;
      w[BIT_LSB +: 4]      = bsel;
      w[CH_LSB +: 2]       = ch;
      w[LOAD_BIT]          = 1'b1;
      w[RITC_BIT]          = rsel;
      return w;
   endfunction

endpackage

// File: rtl/ritc_delay_trainer_if.sv
// Control, sample and IDELAY-bus signals of the delay trainer.
interface ritc_delay_trainer_if;

   logic        start_i;
   logic        ritc_i;
   logic [1:0]  ch_i;
   logic [3:0]  bit_i;
   logic [7:0]  sample_i;
   logic        sample_valid_i;

   logic        dly_addr_o;
   logic [31:0] dly_dat_o;
   logic        dly_wr_o;
   logic        busy_o;
   logic        done_o;
   logic        fail_o;
   logic [4:0]  center_o;
   logic [5:0]  width_o;
   logic [31:0] pass_map_o;

   modport master (
      input  start_i, ritc_i, ch_i, bit_i, sample_i, sample_valid_i,
      output dly_addr_o, dly_dat_o, dly_wr_o, busy_o, done_o, fail_o,
             center_o, width_o, pass_map_o
   );

   modport slave (
      output start_i, ritc_i, ch_i, bit_i, sample_i, sample_valid_i,
      input  dly_addr_o, dly_dat_o, dly_wr_o, busy_o, done_o, fail_o,
             center_o, width_o, pass_map_o
   );

endinterface

// File: rtl/ritc_delay_trainer_eye_tracker.sv
// Longest-passing-run tracker over an ascending tap sweep, with window centre.
module ritc_eye_tracker
   import ritc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             rec,
   input  logic             pass,
   input  logic [TAP_W-1:0] tap,
   output logic [5:0]       best_len,
   output logic [TAP_W-1:0] center
);

   logic [5:0]       cur_len;
   logic [TAP_W-1:0] cur_start;
   logic [TAP_W-1:0] best_start;
   logic [5:0]       run_len;
   logic [TAP_W-1:0] run_start;

   always_comb begin
      run_len   = cur_len + 6'd1;
      run_start = (cur_len == 6'd0) ? tap : cur_start;
   end

   // Strict greater-than keeps the earliest of equally long windows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_len    <= '0;
         cur_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
      end else if (clear) begin
         cur_len    <= '0;
         cur_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
      end else if (rec) begin
         if (pass) begin
            cur_len   <= run_len;
            cur_start <= run_start;
            if (run_len > best_len) begin
               best_len   <= run_len;
               best_start <= run_start;
            end
         end else begin
            cur_len <= '0;
         end
      end
   end

   // The window never crosses tap 31, so the sum cannot wrap.
   assign center = best_start + best_len[5:1];

endmodule

// File: rtl/ritc_delay_trainer.sv
// Per-bit IDELAY eye scan: sweep taps 0..31, score each against PATTERN, load the centre.
module ritc_delay_trainer
   import ritc_pkg::*;
#(
   parameter logic [7:0] PATTERN        = 8'hA5,
   parameter int         N_SAMPLES      = 16,
   parameter int         SETTLE_CYCLES  = 64,
   parameter int         TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   ritc_delay_trainer_if.master bus
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       SAMPLE_LAST = 8'(N_SAMPLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TAP_W-1:0] TAP_LAST    = '1;

   state_t           state;
   state_t           state_nx;

   logic [TAP_W-1:0] tap;
   logic [SET_W-1:0] settle_cnt;
   logic [7:0]       sample_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tap_ok;

   logic             sel_ritc;
   logic [1:0]       sel_ch;
   logic [3:0]       sel_bit;

   logic [31:0]      dly_dat;
   logic             fail;
   logic [4:0]       center;
   logic [5:0]       width;
   logic [31:0]      pass_map;

   logic             accept;
   logic             sel_ok;
   logic             sample_done;
   logic             tmo_hit;
   logic             rec;
   logic             load_dat;
   logic [TAP_W-1:0] wr_tap;
   logic             wr_ritc;
   logic [1:0]       wr_ch;
   logic [3:0]       wr_bit;

   logic [5:0]       trk_len;
   logic [TAP_W-1:0] trk_center;

   ritc_eye_tracker u_tracker (
      .clk      (clk_i),
      .rst      (rst_i),
      .clear    (accept),
      .rec      (rec),
      .pass     (tap_ok),
      .tap      (tap),
      .best_len (trk_len),
      .center   (trk_center)
   );

   always_comb begin
      accept      = (state == ST_IDLE) && bus.start_i;
      sel_ok      = sel_legal(bus.ch_i, bus.bit_i);
      sample_done = bus.sample_valid_i && (sample_cnt == SAMPLE_LAST);
      tmo_hit     = (tmo_cnt == TMO_LAST);
      rec         = (state == ST_RECORD);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      bus.dly_wr_o   = 1'b0;
      bus.dly_addr_o = 1'b0;
      bus.busy_o     = (state != ST_IDLE);
      bus.done_o     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start_i) state_nx = sel_ok ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: begin
            bus.dly_wr_o   = 1'b1;
            bus.dly_addr_o = 1'b1;
            state_nx       = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state_nx = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (sample_done)  state_nx = ST_RECORD;
            else if (tmo_hit) state_nx = ST_DONE;
         end
         ST_RECORD: begin
            state_nx = (tap == TAP_LAST) ? ST_CENTER : ST_WRITE;
         end
         ST_CENTER: begin
            state_nx = (trk_len == 6'd0) ? ST_DONE : ST_FINAL_WRITE;
         end
         ST_FINAL_WRITE: begin
            bus.dly_wr_o   = 1'b1;
            bus.dly_addr_o = 1'b1;
            state_nx       = ST_DONE;
         end
         ST_DONE: begin
            bus.done_o = 1'b1;
            state_nx   = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The write word is registered on entry to a write state so it is stable
   // for the strobe cycle and then holds until the next write.
   always_comb begin
      load_dat = (state_nx == ST_WRITE) || (state_nx == ST_FINAL_WRITE);
      wr_ritc  = (state == ST_IDLE) ? bus.ritc_i : sel_ritc;
      wr_ch    = (state == ST_IDLE) ? bus.ch_i   : sel_ch;
      wr_bit   = (state == ST_IDLE) ? bus.bit_i  : sel_bit;
      case (state)
         ST_RECORD: wr_tap = tap + 5'd1;
         ST_CENTER: wr_tap = trk_center;
         default:   wr_tap = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tap        <= '0;
         settle_cnt <= '0;
         sample_cnt <= '0;
         tmo_cnt    <= '0;
         tap_ok     <= 1'b0;
         sel_ritc   <= 1'b0;
         sel_ch     <= '0;
         sel_bit    <= '0;
         dly_dat    <= '0;
         fail       <= 1'b0;
         center     <= '0;
         width      <= '0;
         pass_map   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  sel_ritc <= bus.ritc_i;
                  sel_ch   <= bus.ch_i;
                  sel_bit  <= bus.bit_i;
                  tap      <= '0;
                  fail     <= ~sel_ok;
                  center   <= '0;
                  width    <= '0;
                  pass_map <= '0;
               end
            end
            ST_WRITE: begin
               settle_cnt <= '0;
               sample_cnt <= '0;
               tmo_cnt    <= '0;
               tap_ok     <= 1'b1;
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
            end
            ST_SAMPLE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (bus.sample_valid_i) begin
                  sample_cnt <= sample_cnt + 8'd1;
                  if (bus.sample_i != PATTERN) tap_ok <= 1'b0;
               end
               if (tmo_hit && !sample_done) begin
                  fail   <= 1'b1;
                  center <= '0;
               end
            end
            ST_RECORD: begin
               pass_map[tap] <= tap_ok;
               if (tap != TAP_LAST) tap <= tap + 5'd1;
            end
            ST_CENTER: begin
               width <= trk_len;
               if (trk_len == 6'd0) begin
                  fail   <= 1'b1;
                  center <= '0;
               end else begin
                  center <= trk_center;
               end
            end
            default: ;
         endcase
         if (load_dat) dly_dat <= dly_word(wr_tap, wr_ritc, wr_ch, wr_bit);
      end
   end

   assign bus.dly_dat_o  = dly_dat;
   assign bus.fail_o     = fail;
   assign bus.center_o   = center;
   assign bus.width_o    = width;
   assign bus.pass_map_o = pass_map;

endmodule

// File: tb/tb_ritc_delay_trainer.sv
// Scoreboarded bench for the RITC delay trainer with a behavioural IDELAY/deserializer model.
module tb_ritc_delay_trainer;

   localparam logic [7:0] PAT     = 8'hA5;
   localparam int         NSMP    = 4;
   localparam int         SETTLE  = 4;
   localparam int         TIMEOUT = 64;

   typedef struct packed {
      logic        fail;
      logic [4:0]  center;
      logic [5:0]  width;
      logic [31:0] map;
   } res_t;

   logic clk;
   logic rst;

   ritc_delay_trainer_if bus ();

   ritc_delay_trainer #(
      .PATTERN        (PAT),
      .N_SAMPLES      (NSMP),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          wr_cyc = 0;
   int          done_cyc = 0;
   int          start_cyc = 0;
   int          vmode = 1;
   logic [31:0] pass_mask = '0;
   logic [4:0]  ide_tap = '0;
   logic [7:0]  vcnt = '0;

   logic [31:0] exp_wr[$];
   res_t        exp_res[$];

   function automatic logic [31:0] exp_word(input logic [4:0] t, input logic r,
                                            input logic [1:0] ch, input logic [3:0] b);
      return {18'd0, r, 1'b1, ch, b, 1'b0, t};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.dly_wr_o) begin
         ide_tap <= bus.dly_dat_o[4:0];
         vcnt    <= '0;
      end else if (bus.sample_valid_i) begin
         vcnt <= vcnt + 8'd1;
      end
   end

   // Deserializer model: passing taps return the pattern, failing taps alternate with garbage.
   initial begin
      bus.sample_valid_i = 1'b0;
      bus.sample_i       = '0;
      forever begin
         @(negedge clk);
         case (vmode)
            0:       bus.sample_valid_i = 1'b0;
            1:       bus.sample_valid_i = 1'b1;
            default: bus.sample_valid_i = ($urandom_range(0, 3) != 0);
         endcase
         if (pass_mask[ide_tap]) bus.sample_i = PAT;
         else                    bus.sample_i = vcnt[0] ? PAT : 8'h5A;
      end
   end

   always @(negedge clk) begin
      if (bus.dly_wr_o === 1'b1) begin
         logic [31:0] e;
         wr_cnt++;
         wr_cyc = cyc;
         total++;
         if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got dat=%h want no write", bus.dly_dat_o);
         end else begin
            e = exp_wr.pop_front();
            if (bus.dly_dat_o !== e || bus.dly_addr_o !== 1'b1) begin
               bad++;
               $display("FAIL write_word got dat=%h addr=%b want dat=%h addr=1",
                        bus.dly_dat_o, bus.dly_addr_o, e);
            end
         end
      end
      if (bus.done_o === 1'b1) begin
         res_t e, g;
         done_cnt++;
         done_cyc = cyc;
         g = {bus.fail_o, bus.center_o, bus.width_o, bus.pass_map_o};
         total++;
         if (exp_res.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done got %h want no done", g);
         end else begin
            e = exp_res.pop_front();
            if (g !== e || bus.busy_o !== 1'b1) begin
               bad++;
               $display("FAIL result got fail=%b center=%0d width=%0d map=%h busy=%b want fail=%b center=%0d width=%0d map=%h busy=1",
                        g.fail, g.center, g.width, g.map, bus.busy_o, e.fail, e.center, e.width, e.map);
            end
         end
      end
   end

   task automatic launch(input logic [31:0] mask, input logic r, input logic [1:0] ch,
                         input logic [3:0] b, input logic [4:0] ec, input logic [5:0] ew,
                         input logic ef);
      res_t e;
      pass_mask = mask;
      for (int t = 0; t < 32; t++) exp_wr.push_back(exp_word(5'(t), r, ch, b));
      if (!ef) exp_wr.push_back(exp_word(ec, r, ch, b));
      e = {ef, ec, ew, ef ? 32'd0 : mask};
      if (ef) e.map = mask;
      exp_res.push_back(e);
      @(negedge clk);
      bus.ritc_i  = r;
      bus.ch_i    = ch;
      bus.bit_i   = b;
      bus.start_i = 1'b1;
      start_cyc   = cyc;
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(input int prev, input int budget, output bit expired);
      int n;
      n = 0;
      while (done_cnt == prev && n < budget) begin
         @(negedge clk);
         n++;
      end
      expired = (done_cnt == prev);
   endtask

   task automatic test_reset();
      total++;
      if ({bus.dly_addr_o, bus.dly_dat_o, bus.dly_wr_o, bus.busy_o, bus.done_o, bus.fail_o,
           bus.center_o, bus.width_o, bus.pass_map_o} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got dat=%h wr=%b busy=%b fail=%b map=%h want all 0",
                  bus.dly_dat_o, bus.dly_wr_o, bus.busy_o, bus.fail_o, bus.pass_map_o);
      end
   endtask

   task automatic test_centered();
      int w0, d0;
      bit to;
      w0 = wr_cnt; d0 = done_cnt;
      launch(32'h000F_FC00, 1'b1, 2'd2, 4'd10, 5'd15, 6'd10, 1'b0);
      wait_done(d0, 2000, to);
      total++;
      if (to) begin bad++; $display("FAIL centered_done got none in 2000 cycles want done"); end
      repeat (3) @(negedge clk);
      total++;
      if (wr_cnt - w0 != 33) begin bad++; $display("FAIL centered_writes got %0d want 33", wr_cnt - w0); end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL centered_done_pulses got %0d want 1", done_cnt - d0); end
      total++;
      if (bus.dly_dat_o !== 32'h0000_3A8F) begin
         bad++; $display("FAIL centered_last_word got %h want 00003a8f", bus.dly_dat_o);
      end
      total++;
      if ({bus.busy_o, bus.fail_o, bus.center_o, bus.width_o} !== {2'b00, 5'd15, 6'd10}) begin
         bad++; $display("FAIL centered_idle got busy=%b fail=%b center=%0d width=%0d want 0 0 15 10",
                         bus.busy_o, bus.fail_o, bus.center_o, bus.width_o);
      end
   endtask

   task automatic test_tie();
      int d0;
      bit to;
      d0 = done_cnt;
      vmode = 2;
      launch(32'h00F0_003C, 1'b0, 2'd0, 4'd0, 5'd4, 6'd4, 1'b0);
      wait_done(d0, 3000, to);
      vmode = 1;
      total++;
      if (to) begin bad++; $display("FAIL tie_done got none in 3000 cycles want done"); end
      repeat (2) @(negedge clk);
      total++;
      if (bus.center_o !== 5'd4 || bus.width_o !== 6'd4) begin
         bad++; $display("FAIL tie_center got center=%0d width=%0d want 4 4", bus.center_o, bus.width_o);
      end
   endtask

   task automatic test_no_pass();
      int w0, d0;
      bit to;
      w0 = wr_cnt; d0 = done_cnt;
      launch(32'h0, 1'b0, 2'd1, 4'd3, 5'd0, 6'd0, 1'b1);
      wait_done(d0, 2000, to);
      total++;
      if (to) begin bad++; $display("FAIL nopass_done got none in 2000 cycles want done"); end
      repeat (3) @(negedge clk);
      total++;
      if (wr_cnt - w0 != 32) begin bad++; $display("FAIL nopass_writes got %0d want 32", wr_cnt - w0); end
      total++;
      if (bus.fail_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         bad++; $display("FAIL nopass_sticky got fail=%b busy=%b want 1 0", bus.fail_o, bus.busy_o);
      end
   endtask

   task automatic test_timeout();
      int w0, d0;
      bit to;
      w0 = wr_cnt; d0 = done_cnt;
      vmode = 0;
      pass_mask = '1;
      exp_wr.push_back(exp_word(5'd0, 1'b1, 2'd0, 4'd7));
      exp_res.push_back({1'b1, 5'd0, 6'd0, 32'd0});
      @(negedge clk);
      bus.ritc_i = 1'b1; bus.ch_i = 2'd0; bus.bit_i = 4'd7; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_done(d0, 500, to);
      vmode = 1;
      total++;
      if (to) begin bad++; $display("FAIL timeout_done got none in 500 cycles want done"); end
      repeat (3) @(negedge clk);
      total++;
      if (wr_cnt - w0 != 1) begin bad++; $display("FAIL timeout_writes got %0d want 1", wr_cnt - w0); end
      total++;
      if (done_cyc - wr_cyc != 1 + SETTLE + TIMEOUT) begin
         bad++; $display("FAIL timeout_latency got %0d want %0d", done_cyc - wr_cyc, 1 + SETTLE + TIMEOUT);
      end
      total++;
      if (bus.fail_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got fail=%b want 1", bus.fail_o); end
   endtask

   task automatic test_illegal();
      int w0, d0;
      bit to;
      logic [1:0] chs [2];
      logic [3:0] bits [2];
      chs[0] = 2'd0; bits[0] = 4'd13;
      chs[1] = 2'd3; bits[1] = 4'd2;
      for (int k = 0; k < 2; k++) begin
         w0 = wr_cnt; d0 = done_cnt;
         exp_res.push_back({1'b1, 5'd0, 6'd0, 32'd0});
         @(negedge clk);
         bus.ritc_i = 1'b0; bus.ch_i = chs[k]; bus.bit_i = bits[k]; bus.start_i = 1'b1;
         start_cyc = cyc;
         @(negedge clk);
         bus.start_i = 1'b0;
         wait_done(d0, 20, to);
         total++;
         if (to || done_cyc != start_cyc + 1) begin
            bad++; $display("FAIL illegal_latency case=%0d got %0d want 1", k, done_cyc - start_cyc);
         end
         repeat (3) @(negedge clk);
         total++;
         if (wr_cnt != w0 || bus.fail_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL illegal_state case=%0d got writes=%0d fail=%b busy=%b want 0 1 0",
                            k, wr_cnt - w0, bus.fail_o, bus.busy_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      int w0, d0, n;
      bit to;
      w0 = wr_cnt; d0 = done_cnt;
      launch(32'hFFFF_FFFF, 1'b0, 2'd1, 4'd15, 5'd16, 6'd32, 1'b0);
      n = 0;
      while (wr_cnt < w0 + 5 && n < 500) begin @(negedge clk); n++; end
      bus.ritc_i = 1'b1; bus.ch_i = 2'd2; bus.bit_i = 4'd3; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_done(d0, 2000, to);
      total++;
      if (to) begin bad++; $display("FAIL b2b_done got none in 2000 cycles want done"); end
      // Immediately follow with a scan whose runs touch both ends of the tap range.
      d0 = done_cnt;
      launch(32'hF000_0003, 1'b1, 2'd0, 4'd11, 5'd30, 6'd4, 1'b0);
      wait_done(d0, 2000, to);
      total++;
      if (to) begin bad++; $display("FAIL edge_done got none in 2000 cycles want done"); end
      repeat (3) @(negedge clk);
      total++;
      if (wr_cnt - w0 != 66 || done_cnt - d0 != 1) begin
         bad++; $display("FAIL b2b_counts got writes=%0d want 66", wr_cnt - w0);
      end
      total++;
      if (exp_wr.size() != 0 || exp_res.size() != 0) begin
         bad++; $display("FAIL b2b_queues got wr=%0d res=%0d pending want 0 0", exp_wr.size(), exp_res.size());
      end
   endtask

   task automatic test_reset_mid();
      int w0, d0, n;
      bit to;
      w0 = wr_cnt; d0 = done_cnt;
      launch(32'h0000_FF00, 1'b1, 2'd1, 4'd6, 5'd12, 6'd8, 1'b0);
      n = 0;
      while (wr_cnt < w0 + 8 && n < 500) begin @(negedge clk); n++; end
      total++;
      if (wr_cnt != w0 + 8) begin bad++; $display("FAIL rstmid_reach got writes=%0d want 8", wr_cnt - w0); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({bus.dly_addr_o, bus.dly_dat_o, bus.dly_wr_o, bus.busy_o, bus.done_o, bus.fail_o,
           bus.center_o, bus.width_o, bus.pass_map_o} !== '0) begin
         bad++; $display("FAIL rstmid_outputs got dat=%h busy=%b map=%h want all 0",
                         bus.dly_dat_o, bus.busy_o, bus.pass_map_o);
      end
      exp_wr.delete();
      exp_res.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      total++;
      if (wr_cnt != w0 + 8 || done_cnt != d0) begin
         bad++; $display("FAIL rstmid_quiet got writes=%0d dones=%0d want 8 0", wr_cnt - w0, done_cnt - d0);
      end
      w0 = wr_cnt;
      launch(32'h0000_FF00, 1'b0, 2'd2, 4'd15, 5'd12, 6'd8, 1'b0);
      wait_done(d0, 2000, to);
      total++;
      if (to) begin bad++; $display("FAIL rstmid_rescan got no done in 2000 cycles want done"); end
      repeat (3) @(negedge clk);
      total++;
      if (wr_cnt - w0 != 33 || bus.center_o !== 5'd12) begin
         bad++; $display("FAIL rstmid_rescan_result got writes=%0d center=%0d want 33 12",
                         wr_cnt - w0, bus.center_o);
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.ritc_i  = 1'b0;
      bus.ch_i    = '0;
      bus.bit_i   = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      test_centered();
      test_tie();
      test_no_pass();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
